noc_local_inject_arbiter: RTL and testbench
===========================================

// Module: noc_local_inject_arbiter
// PURPOSE
//  Shares one router local input port among NUM_REQ on-node flit sources (test nodes, AXI bridges).
//  Round-robin arbitration at packet granularity with wormhole lock (header..tail from one owner).
//  Registered single-entry output stage gives 1-cycle latency at full throughput.
//  Sits between the node-side senders and the router local-port receiver.
// PARAMETERS
//  NUM_REQ      4                 number of requesters, 2..8
//  DATA_W       `Noc_Data_Width   flit width
//  WDOG_CYCLES  256               lock-stall limit in cycles; used only with NOC_INJ_ARB_WDOG_EN
// PORTS
//  noc_clk        in   1              clock
//  noc_rst_n      in   1              reset, asynchronous, active-low
//  req_valid      in   NUM_REQ        per-requester flit valid
//  req_ready      out  NUM_REQ        per-requester flit accept (combinational)
//  req_flit       in   NUM_REQ*DATA_W requester i flit at [i*DATA_W +: DATA_W]
//  req_is_header  in   NUM_REQ        flit is packet header
//  req_is_tail    in   NUM_REQ        flit is packet tail
//  out_valid      out  1              flit to router valid (registered)
//  out_ready      in   1              router accepts flit
//  out_flit       out  DATA_W         flit to router (registered)
//  out_is_header  out  1              header marker (registered)
//  out_is_tail    out  1              tail marker (registered)
//  arb_owner      out  3              current/last granted requester index
//  arb_err        out  1              sticky watchdog error; constant 0 without macro
// BEHAVIOUR
//  Reset: out_valid/out_is_header/out_is_tail=0, out_flit=0, state=IDLE, rr_ptr=0, arb_owner=0, arb_err=0.
//  slot_free = !out_valid | out_ready. Transfer i happens when req_valid[i] & req_ready[i].
//  On transfer: out_* <= req_*[i], out_valid <= 1 next cycle. If slot_free and no transfer: out_valid <= 0.
//  If !slot_free: out_* hold; all req_ready = 0.
//  FSM IDLE: candidates = req_valid & req_is_header. Winner = first candidate at or after rr_ptr (wrapping).
//   req_ready[winner] = slot_free; others 0. Non-header valid flits in IDLE never readied (stall).
//   On winner transfer: arb_owner <= winner; if header not tail -> LOCK; if header & tail (1-flit pkt)
//   stay IDLE, rr_ptr <= winner+1 mod NUM_REQ.
//  FSM LOCK: req_ready[arb_owner] = slot_free; all others 0, regardless of headers presented.
//   Transfer with tail -> IDLE, rr_ptr <= arb_owner+1 mod NUM_REQ. Header arriving in LOCK from owner
//   is forwarded unchanged (no check).
//  Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,..,NUM_REQ-1,0.
//  Simultaneous: tail accepted and new header same cycle impossible (one transfer/cycle); next header
//   arbitration occurs the cycle after the tail transfer.
//  Reset mid-packet: all state cleared asynchronously; partial packet in router is not repaired.
// CONFIGURATION
//  NOC_INJ_ARB_WDOG_EN defined: in LOCK a counter increments each cycle with no owner transfer, clears on
//   transfer; at WDOG_CYCLES-1 -> forced IDLE, rr_ptr <= arb_owner+1, arb_err <= 1 (sticky until reset);
//   a fabricated tail is NOT emitted. Counter cleared in IDLE.
//  Not defined: no counter, LOCK held indefinitely, arb_err tied 0.
// TESTING
//  T1 reset: assert noc_rst_n=0 mid-LOCK -> out_valid=0, arb_owner=0, next grant from req 0.
//  T2 req0,req2 each send 3-flit pkt (H,0xFF..,T) at once, out_ready=1 -> out order H0,D0,T0,H2,D2,T2,
//   first out_valid 1 cycle after H0 transfer, no bubbles.
//  T3 all 4 requesters stream 1-flit pkts (H&T) -> grants 0,1,2,3,0,1 every cycle.
//  T4 req1 locked, req3 presents header -> req_ready[3]=0 until req1 tail transfers; req3 granted next.
//  T5 out_ready=0 for 5 cycles mid-packet -> out_flit stable, all req_ready=0, no flit lost/duplicated.
//  T6 (WDOG_EN, WDOG_CYCLES=16) req0 sends header then idles -> after 16 stalled cycles state IDLE,
//   arb_err=1, req1 header then granted.

Source files
------------

// File: rtl/noc_local_inject_arbiter.sv
// Packet-granular round-robin arbiter that shares one router local input port among NUM_REQ node-side flit sources.
// Optional lock-stall watchdog enabled by defining NOC_INJ_ARB_WDOG_EN.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_local_inject_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = `Noc_Data_Width,
  parameter int unsigned WDOG_CYCLES = 256
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_is_header,
  input  logic [NUM_REQ-1:0]        req_is_tail,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_flit,
  output logic                      out_is_header,
  output logic                      out_is_tail,
  output logic [2:0]                arb_owner,
  output logic                      arb_err
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W:0]     scan;
  logic               win_found;
  logic               grant_en;
  logic               slot_free;
  logic               xfer;
  logic               timeout;
  logic [DATA_W-1:0]  sel_flit;
  logic               sel_header;
  logic               sel_tail;

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 2) begin : g_param_check
    $error("noc_local_inject_arbiter: parameter out of range");
  end

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (32'(idx) + 32'd1 >= NUM_REQ) return '0;
    return idx + IDX_W'(1);
  endfunction

  assign slot_free = !out_valid || out_ready;
  assign xfer      = |(req_valid & req_ready);

  // First header-carrying requester at or after rr_ptr, wrapping around.
  always_comb begin : winner
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan >= (IDX_W+1)'(NUM_REQ)) scan = scan - (IDX_W+1)'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && req_valid[i] && req_is_header[i] && scan == (IDX_W+1)'(i)) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin : state_reg
    if (!noc_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin : fsm_next
    state_next = state;
    case (state)
      IDLE:    if (xfer && !sel_tail) state_next = LOCK;
      LOCK:    if ((xfer && sel_tail) || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant decode: arbitration winner in IDLE, locked owner in LOCK.
  always_comb begin : fsm_out
    grant_en  = 1'b0;
    sel_idx   = arb_owner;
    req_ready = '0;
    case (state)
      IDLE: begin
        grant_en = win_found;
        sel_idx  = win_idx;
      end
      LOCK:    grant_en = 1'b1;
      default: grant_en = 1'b0;
    endcase
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_en && slot_free && (sel_idx == IDX_W'(i));
    end
  end

  always_comb begin : flit_mux
    sel_flit   = '0;
    sel_header = 1'b0;
    sel_tail   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_flit   = req_flit[i*DATA_W +: DATA_W];
        sel_header = req_is_header[i];
        sel_tail   = req_is_tail[i];
      end
    end
  end

  // Owner is captured on the header grant; the pointer moves past the owner once its packet ends.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin : arb_reg
    if (!noc_rst_n) begin
      rr_ptr    <= '0;
      arb_owner <= '0;
    end else begin
      if (state == IDLE && xfer) arb_owner <= sel_idx;
      if (xfer && sel_tail)      rr_ptr    <= wrap_inc(sel_idx);
      else if (timeout)          rr_ptr    <= wrap_inc(arb_owner);
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin : out_stage
    if (!noc_rst_n) begin
      out_valid     <= 1'b0;
      out_flit      <= '0;
      out_is_header <= 1'b0;
      out_is_tail   <= 1'b0;
    end else if (xfer) begin
      out_valid     <= 1'b1;
      out_flit      <= sel_flit;
      out_is_header <= sel_header;
      out_is_tail   <= sel_tail;
    end else if (slot_free) begin
      out_valid     <= 1'b0;
    end
  end

`ifdef NOC_INJ_ARB_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES) + 1;

  logic [WDOG_W-1:0] wdog_cnt;
  logic              err_q;

  // Releases a lock whose owner stopped sending; no tail is fabricated.
  assign timeout = (state == LOCK) && !xfer && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
  assign arb_err = err_q;

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin : wdog_reg
    if (!noc_rst_n) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != LOCK || xfer) wdog_cnt <= '0;
      else                       wdog_cnt <= wdog_cnt + WDOG_W'(1);
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Directed bench for noc_local_inject_arbiter: reset, packet ordering, fairness, lock, backpressure, watchdog.
`timescale 1ns/1ps

module tb_noc_local_inject_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;

  logic            noc_clk;
  logic            noc_rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*DW-1:0] req_flit;
  logic [NR-1:0]   req_is_header;
  logic [NR-1:0]   req_is_tail;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_flit;
  logic            out_is_header;
  logic            out_is_tail;
  logic [2:0]      arb_owner;
  logic            arb_err;

  int checks = 0;
  int errors = 0;
  logic [33:0] q [NR][$];
  logic [3:0]  rdy;

  noc_local_inject_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .WDOG_CYCLES(16)
  ) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_flit(req_flit),
    .req_is_header(req_is_header), .req_is_tail(req_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_is_header(out_is_header), .out_is_tail(out_is_tail),
    .arb_owner(arb_owner), .arb_err(arb_err)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] fl(input logic h, input logic t, input logic [31:0] d);
    return {h, t, d};
  endfunction

  // Present queue heads, capture ready before the edge, pop accepted flits after it.
  task automatic tick(output logic [3:0] r);
    for (int i = 0; i < NR; i++) begin
      if (q[i].size() != 0) begin
        req_valid[i] = 1'b1;
        {req_is_header[i], req_is_tail[i], req_flit[i*DW +: DW]} = q[i][0];
      end else begin
        req_valid[i]     = 1'b0;
        req_is_header[i] = 1'b0;
        req_is_tail[i]   = 1'b0;
      end
    end
    #1;
    r = req_ready;
    @(posedge noc_clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (r[i] && req_valid[i]) q[i].delete(0);
    end
  endtask

  initial begin
    logic [31:0] exp_t2 [6];
    noc_rst_n     = 1'b0;
    out_ready     = 1'b1;
    req_valid     = '0;
    req_flit      = '0;
    req_is_header = '0;
    req_is_tail   = '0;
    repeat (2) @(posedge noc_clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_flit", out_flit, 32'd0);
    chk("rst_arb_owner", 32'(arb_owner), 32'd0);
    chk("rst_arb_err", 32'(arb_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    noc_rst_n = 1'b1;

    // T2: two 3-flit packets offered together, req0 first then req2, back to back.
    q[0].push_back(fl(1'b1, 1'b0, 32'h0000_00A0));
    q[0].push_back(fl(1'b0, 1'b0, 32'hFF00_0001));
    q[0].push_back(fl(1'b0, 1'b1, 32'h0000_00A2));
    q[2].push_back(fl(1'b1, 1'b0, 32'h0000_00C0));
    q[2].push_back(fl(1'b0, 1'b0, 32'hFF00_0003));
    q[2].push_back(fl(1'b0, 1'b1, 32'h0000_00C2));
    exp_t2 = '{32'h0000_00A0, 32'hFF00_0001, 32'h0000_00A2,
               32'h0000_00C0, 32'hFF00_0003, 32'h0000_00C2};
    for (int k = 0; k < 6; k++) begin
      tick(rdy);
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_flit", out_flit, exp_t2[k]);
      chk("t2_header", 32'(out_is_header), 32'(k % 3 == 0));
      chk("t2_tail", 32'(out_is_tail), 32'(k % 3 == 2));
      chk("t2_owner", 32'(arb_owner), (k < 3) ? 32'd0 : 32'd2);
    end
    tick(rdy);
    chk("t2_drain", 32'(out_valid), 32'd0);

    // T1: asynchronous reset while req1 holds the lock.
    q[1].push_back(fl(1'b1, 1'b0, 32'h0000_1100));
    q[1].push_back(fl(1'b0, 1'b0, 32'h0000_1101));
    q[1].push_back(fl(1'b0, 1'b1, 32'h0000_1102));
    tick(rdy);
    chk("t1_pre_owner", 32'(arb_owner), 32'd1);
    chk("t1_pre_valid", 32'(out_valid), 32'd1);
    #2;
    noc_rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", 32'(out_valid), 32'd0);
    chk("t1_rst_owner", 32'(arb_owner), 32'd0);
    for (int i = 0; i < NR; i++) q[i].delete();
    req_valid     = '0;
    req_is_header = '0;
    req_is_tail   = '0;
    @(posedge noc_clk);
    #1;
    noc_rst_n = 1'b1;

    // T3: all requesters stream single-flit packets; grants rotate from req0.
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < NR; i++)
        q[i].push_back(fl(1'b1, 1'b1, 32'h300 + 32'(i * 16 + n)));
    for (int k = 0; k < 6; k++) begin
      tick(rdy);
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_owner", 32'(arb_owner), 32'(k % 4));
      chk("t3_flit", out_flit, 32'h300 + 32'((k % 4) * 16 + k / 4));
    end
    for (int i = 0; i < NR; i++) q[i].delete();
    tick(rdy);
    chk("t3_drain", 32'(out_valid), 32'd0);

    // T4: req3 header waits while req1 holds the lock, then wins.
    q[1].push_back(fl(1'b1, 1'b0, 32'h4100));
    q[1].push_back(fl(1'b0, 1'b0, 32'h4101));
    q[1].push_back(fl(1'b0, 1'b0, 32'h4102));
    q[1].push_back(fl(1'b0, 1'b1, 32'h4103));
    tick(rdy);
    chk("t4_owner1", 32'(arb_owner), 32'd1);
    chk("t4_hdr1", out_flit, 32'h4100);
    q[3].push_back(fl(1'b1, 1'b0, 32'h4300));
    q[3].push_back(fl(1'b0, 1'b1, 32'h4301));
    for (int k = 1; k < 4; k++) begin
      tick(rdy);
      chk("t4_lock_ready", 32'(rdy), 32'h2);
      chk("t4_lock_flit", out_flit, 32'h4100 + 32'(k));
    end
    tick(rdy);
    chk("t4_next_ready", 32'(rdy), 32'h8);
    chk("t4_next_owner", 32'(arb_owner), 32'd3);
    chk("t4_next_flit", out_flit, 32'h4300);
    tick(rdy);
    chk("t4_tail_flit", out_flit, 32'h4301);
    tick(rdy);
    chk("t4_drain", 32'(out_valid), 32'd0);

    // T5: router backpressure mid-packet.
    q[0].push_back(fl(1'b1, 1'b0, 32'h5000));
    q[0].push_back(fl(1'b0, 1'b0, 32'h5001));
    q[0].push_back(fl(1'b0, 1'b0, 32'h5002));
    q[0].push_back(fl(1'b0, 1'b1, 32'h5003));
    tick(rdy);
    tick(rdy);
    chk("t5_pre_flit", out_flit, 32'h5001);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(rdy);
      chk("t5_stall_ready", 32'(rdy), 32'd0);
      chk("t5_stall_valid", 32'(out_valid), 32'd1);
      chk("t5_stall_flit", out_flit, 32'h5001);
    end
    out_ready = 1'b1;
    tick(rdy);
    chk("t5_resume_flit", out_flit, 32'h5002);
    tick(rdy);
    chk("t5_tail_flit", out_flit, 32'h5003);
    chk("t5_tail_mark", 32'(out_is_tail), 32'd1);
    chk("t5_src_empty", 32'(q[0].size()), 32'd0);
    tick(rdy);
    chk("t5_drain", 32'(out_valid), 32'd0);

`ifdef NOC_INJ_ARB_WDOG_EN
    // T6: req0 abandons its packet after the header; the watchdog frees the port.
    q[0].push_back(fl(1'b1, 1'b0, 32'h6000));
    tick(rdy);
    chk("t6_owner0", 32'(arb_owner), 32'd0);
    chk("t6_hdr0", out_flit, 32'h6000);
    q[1].push_back(fl(1'b1, 1'b1, 32'h6100));
    for (int k = 2; k <= 17; k++) begin
      tick(rdy);
      chk("t6_lock_ready", 32'(rdy), 32'h1);
      chk("t6_err", 32'(arb_err), 32'(k == 17));
    end
    tick(rdy);
    chk("t6_free_ready", 32'(rdy), 32'h2);
    chk("t6_free_owner", 32'(arb_owner), 32'd1);
    chk("t6_free_flit", out_flit, 32'h6100);
    chk("t6_err_sticky", 32'(arb_err), 32'd1);
`else
    chk("no_wdog_err", 32'(arb_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
